multi_approach_signal_ctrl: RTL and testbench

Parametrised N-approach intersection controller: round-robin green among N vehicle approaches, with latched demand detection, fixed yellow and all-red clearance, and a per-approach pedestrian head. Adds a FLASH maintenance mode not present in the two-road controller. Sits at the top of the traffic-light datapath and drives lamp decoders directly.

---
 rtl/sig_pkg.sv | 38 +++
 rtl/sig_phase_timer.sv | 30 +++
 rtl/multi_approach_signal_ctrl.sv | 144 ++++++++++++++
 tb/tb_multi_approach_signal_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// sig_pkg: shared definitions for the multi-approach signal controller.
//   - lamp codes driven onto the CAR/PED lamp buses (2 bits per approach)
//   - controller state enum
//   - rr_next(): round-robin scan used to pick the next approach to serve
package sig_pkg;

    // Lamp codes, one 2-bit field per approach on the lamp buses
    localparam logic [1:0] LAMP_RED       = 2'b00;
    localparam logic [1:0] LAMP_YELLOW    = 2'b01;
    localparam logic [1:0] LAMP_GREEN     = 2'b10;
    localparam logic [1:0] LAMP_BLINK_RED = 2'b11;

    // Largest approach count rr_next() can scan; requests are zero-extended to this width
    localparam int MAX_APPR = 32;

    typedef enum logic [1:0] {
        ST_GREEN,
        ST_YELLOW,
        ST_ALLRED,
        ST_FLSH
    } sig_state_t;

    // Returns the first set bit of req scanning cur+1, cur+2, ... modulo n.
    // The scan runs from the farthest offset down so the nearest hit is the
    // last assignment and wins. With no set bit, cur is returned unchanged.
    function automatic int rr_next(input logic [MAX_APPR-1:0] req,
                                   input int n,
                                   input int cur);
        int idx;
        rr_next = cur;
        for (int i = MAX_APPR - 1; i >= 1; i--) begin
            idx = cur + i;
            if (idx >= n) idx = idx - n;
            if (i < n && req[idx[4:0]]) rr_next = idx;
        end
    endfunction

endpackage

// File: rtl/sig_phase_timer.sv
// sig_phase_timer: saturating phase counter with terminal-count flag.
//   CLK   in   clock
//   RST   in   synchronous active-high reset (count to 0)
//   clear in   restart the count at 0 on the next edge (phase change)
//   limit in   terminal count for the current phase
//   done  out  count has reached limit; the counter holds there
module sig_phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Counts up to limit and saturates there, so a green phase with no
    // competing demand can be held indefinitely without wrapping.
    always_ff @(posedge CLK) begin
        if (RST || clear)
            cnt <= '0;
        else if (cnt != limit)
            cnt <= cnt + 1'b1;
    end

    assign done = (cnt == limit);

endmodule

// File: rtl/multi_approach_signal_ctrl.sv
// multi_approach_signal_ctrl: N-approach round-robin intersection controller
// with latched vehicle demand, fixed yellow / all-red clearance and a
// maintenance FLASH mode.
//   CLK     in   clock
//   RST     in   synchronous active-high reset
//   SENSE   in   per-approach vehicle detector (level)
//   FLASH   in   maintenance flash request (level)
//   CAR     out  car lamp per approach, bits [2i+1:2i] = approach i
//   PED     out  pedestrian lamp per crossing, same packing
//   ACTIVE  out  approach owning the current/last green
//   REQ     out  latched demand register
module multi_approach_signal_ctrl
    import sig_pkg::*;
#(
    parameter int N_APPR      = 4,
    parameter int T_GREEN_MIN = 14,
    parameter int T_YELLOW    = 5,
    parameter int T_ALLRED    = 3,
    parameter int CNT_W       = 6,
    localparam int IDX_W      = $clog2(N_APPR)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_APPR-1:0]   SENSE,
    input  logic                FLASH,
    output logic [2*N_APPR-1:0] CAR,
    output logic [2*N_APPR-1:0] PED,
    output logic [IDX_W-1:0]    ACTIVE,
    output logic [N_APPR-1:0]   REQ
);

    sig_state_t        state, state_nxt;
    logic [IDX_W-1:0]  next_q, next_nxt, active_nxt;
    logic [N_APPR-1:0] req_nxt, req_masked;
    logic [CNT_W-1:0]  limit;
    logic              clear, done;

    sig_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .clear (clear),
        .limit (limit),
        .done  (done)
    );

    // State register plus the arbiter registers that move with it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_GREEN;
            ACTIVE <= '0;
            next_q <= '0;
            REQ    <= '0;
        end else begin
            state  <= state_nxt;
            ACTIVE <= active_nxt;
            next_q <= next_nxt;
            REQ    <= req_nxt;
        end
    end

    // Next-state, phase limit and demand latching. The timer is restarted
    // on every state change.
    always_comb begin
        state_nxt  = state;
        active_nxt = ACTIVE;
        next_nxt   = next_q;
        clear      = 1'b0;
        limit      = '0;

        req_masked         = REQ;
        req_masked[ACTIVE] = 1'b0;

        unique case (state)
            ST_GREEN: begin
                limit = CNT_W'(T_GREEN_MIN - 1);
                if (done && (|req_masked || FLASH)) begin
                    state_nxt = ST_YELLOW;
                    clear     = 1'b1;
                    // A FLASH-only exit finds no request and keeps NEXT=ACTIVE
                    next_nxt  = IDX_W'(rr_next(MAX_APPR'(req_masked), N_APPR, int'(ACTIVE)));
                end
            end
            ST_YELLOW: begin
                limit = CNT_W'(T_YELLOW - 1);
                if (done) begin
                    state_nxt = ST_ALLRED;
                    clear     = 1'b1;
                end
            end
            ST_ALLRED: begin
                limit = CNT_W'(T_ALLRED - 1);
                if (done) begin
                    clear = 1'b1;
                    if (FLASH) begin
                        state_nxt = ST_FLSH;
                    end else begin
                        state_nxt  = ST_GREEN;
                        active_nxt = next_q;
                    end
                end
            end
            default: begin
                if (!FLASH) begin
                    state_nxt = ST_ALLRED;
                    next_nxt  = '0;
                    clear     = 1'b1;
                end
            end
        endcase

        // The approach being served never holds demand, including on the
        // edge it gains green, so a detector hit on that edge is dropped.
        req_nxt = REQ | SENSE;
        if (state == ST_GREEN)
            req_nxt[ACTIVE] = 1'b0;
        if (state == ST_ALLRED && state_nxt == ST_GREEN)
            req_nxt[next_q] = 1'b0;
    end

    // Lamp decode straight from registered state
    always_comb begin
        CAR = '0;
        PED = '0;
        for (int i = 0; i < N_APPR; i++) begin
            unique case (state)
                ST_GREEN: begin
                    if (IDX_W'(i) == ACTIVE) CAR[2*i +: 2] = LAMP_GREEN;
                    else                     PED[2*i +: 2] = LAMP_GREEN;
                end
                ST_YELLOW: begin
                    if (IDX_W'(i) == ACTIVE) CAR[2*i +: 2] = LAMP_YELLOW;
                    else                     PED[2*i +: 2] = LAMP_BLINK_RED;
                end
                ST_ALLRED: begin
                    if (IDX_W'(i) != ACTIVE) PED[2*i +: 2] = LAMP_BLINK_RED;
                end
                default: begin
                    CAR[2*i +: 2] = LAMP_BLINK_RED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_approach_signal_ctrl.sv
// tb_multi_approach_signal_ctrl: scenario tables of timed stimulus and
// timed expectations for the default 4-approach controller.
module tb_multi_approach_signal_ctrl;

    typedef enum int {P_G, P_Y, P_R, P_F} phase_t;

    typedef struct {
        int       cyc;
        logic [3:0] sense;
        logic     flash;
        logic     rst;
    } stim_t;

    typedef struct {
        string      name;
        int         cyc;
        phase_t     ph;
        int         act;
        bit         chkReq;
        logic [3:0] req;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] SENSE = '0;
    logic       FLASH = 1'b0;
    logic [7:0] CAR, PED;
    logic [1:0] ACTIVE;
    logic [3:0] REQ;

    int checks = 0;
    int failures = 0;

    stim_t stimQ[$];
    exp_t  expQ[$];

    multi_approach_signal_ctrl dut (
        .CLK    (CLK),
        .RST    (RST),
        .SENSE  (SENSE),
        .FLASH  (FLASH),
        .CAR    (CAR),
        .PED    (PED),
        .ACTIVE (ACTIVE),
        .REQ    (REQ)
    );

    always #5 CLK = ~CLK;

    // Expected car lamps for a phase with the given approach active
    function automatic logic [7:0] carOf(phase_t p, int a);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (p == P_F)                 v[2*i +: 2] = 2'b11;
            else if (i == a && p == P_G)  v[2*i +: 2] = 2'b10;
            else if (i == a && p == P_Y)  v[2*i +: 2] = 2'b01;
        end
        return v;
    endfunction

    // Expected pedestrian lamps for a phase with the given approach active
    function automatic logic [7:0] pedOf(phase_t p, int a);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (i != a && p == P_G)                    v[2*i +: 2] = 2'b10;
            else if (i != a && (p == P_Y || p == P_R)) v[2*i +: 2] = 2'b11;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushStim(int c, logic [3:0] s, logic f, logic r);
        stim_t e;
        e.cyc = c; e.sense = s; e.flash = f; e.rst = r;
        stimQ.push_back(e);
    endtask

    task automatic pushExp(string n, int c, phase_t p, int a, bit chk, logic [3:0] r);
        exp_t e;
        e.name = n; e.cyc = c; e.ph = p; e.act = a; e.chkReq = chk; e.req = r;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(stim_t s);
        SENSE = s.sense;
        FLASH = s.flash;
        RST   = s.rst;
    endtask

    task automatic checkOutput(exp_t e);
        logic [7:0] wc, wp;
        wc = carOf(e.ph, e.act);
        wp = pedOf(e.ph, e.act);
        checks++;
        if (CAR !== wc) begin
            failures++;
            $display("[TB] FAIL %s CAR cyc=%0d got=%h want=%h", e.name, e.cyc, CAR, wc);
        end
        checks++;
        if (PED !== wp) begin
            failures++;
            $display("[TB] FAIL %s PED cyc=%0d got=%h want=%h", e.name, e.cyc, PED, wp);
        end
        checks++;
        if (ACTIVE !== 2'(e.act)) begin
            failures++;
            $display("[TB] FAIL %s ACTIVE cyc=%0d got=%0d want=%0d", e.name, e.cyc, ACTIVE, e.act);
        end
        if (e.chkReq) begin
            checks++;
            if (REQ !== e.req) begin
                failures++;
                $display("[TB] FAIL %s REQ cyc=%0d got=%b want=%b", e.name, e.cyc, REQ, e.req);
            end
        end
    endtask

    // Reset, then walk ncyc cycles; cycle 0 is the first cycle after reset.
    // Stimulus for cycle c is sampled at the edge that ends cycle c.
    task automatic runScenario(string name, int ncyc);
        $display("[TB] scenario %s", name);
        SENSE = '0;
        FLASH = 1'b0;
        RST   = 1'b1;
        step();
        RST   = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            while (expQ.size() > 0 && expQ[0].cyc == c) checkOutput(expQ.pop_front());
            while (stimQ.size() > 0 && stimQ[0].cyc == c) applyStimulus(stimQ.pop_front());
            step();
        end
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s leftover expectations got=%0d want=0", name, expQ.size());
            expQ.delete();
        end
        stimQ.delete();
    endtask

    initial begin
        // Idle after reset: approach 0 green forever
        pushExp("idle0",  0,  P_G, 0, 1, 4'b0000);
        pushExp("idle13", 13, P_G, 0, 1, 4'b0000);
        pushExp("idle14", 14, P_G, 0, 1, 4'b0000);
        pushExp("idle50", 50, P_G, 0, 1, 4'b0000);
        pushExp("idle99", 99, P_G, 0, 1, 4'b0000);
        runScenario("idle", 100);

        // One-cycle SENSE[2]; a second hit on the green-entry edge is dropped
        pushStim(3,  4'b0100, 0, 0);
        pushStim(4,  4'b0000, 0, 0);
        pushStim(21, 4'b0100, 0, 0);
        pushStim(22, 4'b0000, 0, 0);
        pushExp("b_rst",   0,  P_G, 0, 1, 4'b0000);
        pushExp("b_latch", 4,  P_G, 0, 1, 4'b0100);
        pushExp("b_g13",   13, P_G, 0, 0, 4'b0000);
        pushExp("b_y14",   14, P_Y, 0, 0, 4'b0000);
        pushExp("b_y18",   18, P_Y, 0, 0, 4'b0000);
        pushExp("b_r19",   19, P_R, 0, 0, 4'b0000);
        pushExp("b_r21",   21, P_R, 0, 1, 4'b0100);
        pushExp("b_g22",   22, P_G, 2, 1, 4'b0000);
        pushExp("b_hold",  40, P_G, 2, 1, 4'b0000);
        runScenario("single_demand", 45);

        // Round robin from approach 3: serve 1, 2, 3, then wrap to 0
        pushStim(0,  4'b1000, 0, 0);
        pushStim(1,  4'b0000, 0, 0);
        pushStim(25, 4'b0110, 0, 0);
        pushStim(26, 4'b0000, 0, 0);
        pushStim(37, 4'b1000, 0, 0);
        pushStim(38, 4'b0000, 0, 0);
        pushStim(90, 4'b0101, 0, 0);
        pushStim(91, 4'b0000, 0, 0);
        pushExp("c_g3",   22,  P_G, 3, 1, 4'b0000);
        pushExp("c_g1",   44,  P_G, 1, 1, 4'b1100);
        pushExp("c_g1e",  57,  P_G, 1, 0, 4'b0000);
        pushExp("c_y1",   58,  P_Y, 1, 0, 4'b0000);
        pushExp("c_g2",   66,  P_G, 2, 1, 4'b1000);
        pushExp("c_g2e",  79,  P_G, 2, 0, 4'b0000);
        pushExp("c_y2",   80,  P_Y, 2, 0, 4'b0000);
        pushExp("c_g3b",  88,  P_G, 3, 1, 4'b0000);
        pushExp("c_g3e",  101, P_G, 3, 1, 4'b0101);
        pushExp("c_y3",   102, P_Y, 3, 0, 4'b0000);
        pushExp("c_wrap", 110, P_G, 0, 1, 4'b0100);
        runScenario("round_robin", 112);

        // FLASH during approach 1 green, demand latched while flashing
        pushStim(0,  4'b0010, 0, 0);
        pushStim(1,  4'b0000, 0, 0);
        pushStim(40, 4'b0000, 1, 0);
        pushStim(52, 4'b1000, 1, 0);
        pushStim(53, 4'b0000, 1, 0);
        pushStim(60, 4'b0000, 0, 0);
        pushExp("d_g1",   40, P_G, 1, 1, 4'b0000);
        pushExp("d_y1",   41, P_Y, 1, 0, 4'b0000);
        pushExp("d_r1",   46, P_R, 1, 0, 4'b0000);
        pushExp("d_f49",  49, P_F, 1, 1, 4'b0000);
        pushExp("d_f55",  55, P_F, 1, 1, 4'b1000);
        pushExp("d_f60",  60, P_F, 1, 0, 4'b0000);
        pushExp("d_r61",  61, P_R, 1, 1, 4'b1000);
        pushExp("d_r63",  63, P_R, 1, 0, 4'b0000);
        pushExp("d_g0",   64, P_G, 0, 1, 4'b1000);
        pushExp("d_y0",   78, P_Y, 0, 0, 4'b0000);
        runScenario("flash", 80);

        // Detector on the active approach never forces a phase change
        pushStim(0, 4'b0001, 0, 0);
        pushExp("e_g14", 14, P_G, 0, 1, 4'b0000);
        pushExp("e_g30", 30, P_G, 0, 1, 4'b0000);
        pushExp("e_g59", 59, P_G, 0, 1, 4'b0000);
        runScenario("self_demand", 60);

        // Reset in yellow discards demand and restarts the green timer
        pushStim(2,  4'b0110, 0, 0);
        pushStim(3,  4'b0000, 0, 0);
        pushStim(16, 4'b0000, 0, 1);
        pushStim(17, 4'b0000, 0, 0);
        pushStim(18, 4'b0010, 0, 0);
        pushStim(19, 4'b0000, 0, 0);
        pushExp("f_y15",  15, P_Y, 0, 1, 4'b0110);
        pushExp("f_rst",  17, P_G, 0, 1, 4'b0000);
        pushExp("f_g30",  30, P_G, 0, 1, 4'b0010);
        pushExp("f_y31",  31, P_Y, 0, 0, 4'b0000);
        runScenario("reset_mid", 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
